// File: rtl/input_dev_tx.sv
// Input device transmitter: a byte FIFO filled from the device side and handed to the
// processor over a 4-phase in_dev_hs/in_dev_ack handshake.
module input_dev_tx #(
  parameter int PTR_W = 2
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic             ld_en,
  input  logic [7:0]       ld_data,
  input  logic             in_dev_ack,
  output logic             in_dev_hs,
  output logic [7:0]       input_bus,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             ovf,
  output logic [7:0]       tx_cnt,
  output logic [1:0]       tx_state
);

  localparam int DEPTH = 2 ** PTR_W;

  // Handshake: in_dev_hs rises only from IDLE with in_dev_ack low; the byte is
  // consumed on the edge where in_dev_ack is sampled high in PRESENT, and the
  // FSM waits for in_dev_ack to return low before the next byte may be offered.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop, load, wr_acc, wr_drop;
  logic             hs_q;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign wr_acc   = ld_en && (!full || pop);
  assign wr_drop  = ld_en && full && !pop;
  assign in_dev_hs = hs_q;
  assign tx_state  = state;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !in_dev_ack) begin
          load      = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (in_dev_ack) begin
          pop       = 1'b1;
          state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!in_dev_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) state <= IDLE;
    else       state <= state_nxt;
  end

  // Storage has no reset; pointers and count define which entries are live.
  always_ff @(posedge g_clk) begin
    if (wr_acc && !g_clr) mem[wr_ptr] <= ld_data;
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      tx_cnt    <= 8'h00;
      input_bus <= 8'h00;
      hs_q      <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        tx_cnt <= tx_cnt + 8'd1;
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (wr_drop) ovf <= 1'b1;
      if (load) input_bus <= mem[rd_ptr];
      hs_q <= (state_nxt == PRESENT);
    end
  end

endmodule

// File: doc/input_dev_tx.md
INPUT_DEV_TX -- requirements
Module: input_dev_tx

Interface
REQ-001 SHALL have parameter PTR_W, default 2: FIFO pointer width; DEPTH = 2**PTR_W entries of 8 bits.
REQ-002 SHALL have port g_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port g_clr, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port ld_en, input, 1: write strobe from the device side; one byte is offered per cycle while high.
REQ-005 SHALL have port ld_data, input, 8: the byte written when ld_en is high.
REQ-006 SHALL have port in_dev_ack, input, 1: processor acknowledge, "data received".
REQ-007 SHALL have port in_dev_hs, output, 1: "data ready" to the processor; it also drives the processor's interrupt input.
REQ-008 SHALL have port input_bus, output, 8: the byte presented to the processor.
REQ-009 SHALL have ports full and empty, output, 1 each: FIFO status flags.
REQ-010 SHALL have port count, output, PTR_W+1: the number of bytes stored.
REQ-011 SHALL have port ovf, output, 1: sticky flag, set when a write is dropped.
REQ-012 SHALL have port tx_cnt, output, 8: the number of bytes handed over.
REQ-013 SHALL have port tx_state, output, 2: FSM state encoding, IDLE=0, PRESENT=1, WAIT_REL=2.

Function
REQ-014 SHALL implement a circular FIFO with separate read and write pointers, each of which wraps DEPTH-1 -> 0.
- empty = (count == 0).
- full = (count == DEPTH).
REQ-015 SHALL treat a write as accepted when ld_en=1 and (full=0 or a pop occurs in the same cycle); full is evaluated before the clock edge.
REQ-016 SHALL drop a write when ld_en=1, full=1 and no pop occurs; ovf is set and stays set until g_clr; FIFO contents are unchanged.
REQ-017 SHALL, on a simultaneous accepted write and pop, perform both operations and leave count unchanged.
REQ-018 SHALL run a three-state 4-phase handshake FSM:
- IDLE: in_dev_hs=0. If empty=0 and in_dev_ack=0, load the head byte into the output register and go to PRESENT. Otherwise stay in IDLE.
- PRESENT: in_dev_hs=1 and input_bus holds steady. When in_dev_ack=1 is sampled, pop the FIFO, increment tx_cnt and go to WAIT_REL.
- WAIT_REL: in_dev_hs=0. When in_dev_ack=0 is sampled, go to IDLE. Otherwise stay in WAIT_REL.
REQ-019 SHALL drive in_dev_hs and input_bus from registers only; both are combinationally independent of in_dev_ack.
REQ-020 SHALL hold input_bus at the last presented byte in IDLE and WAIT_REL until the next load into PRESENT.
REQ-021 SHALL meet this latency: a byte written at edge k into an empty FIFO with the FSM in IDLE and in_dev_ack=0 makes in_dev_hs=1 after edge k+1.
REQ-022 SHALL not leave IDLE while in_dev_ack=1, so that a stale acknowledge never completes a new transfer.
REQ-023 SHALL ignore a glitch where in_dev_ack rises and falls within PRESENT without being sampled high; only sampled values count.
REQ-024 SHALL let tx_cnt wrap 255 -> 0 without setting any flag.
REQ-025 SHALL allow the fastest throughput of one byte per 3 cycles when in_dev_ack responds in the cycle after each change.

Reset
REQ-026 SHALL, on g_clr=1 at an edge, set the following state regardless of FSM state (including mid-PRESENT):
- FSM to IDLE.
- Both pointers and count to 0, so empty=1 and full=0.
- ovf=0, tx_cnt=0, in_dev_hs=0, input_bus=8'h00.
REQ-027 SHALL ignore a write offered in the same cycle as g_clr=1; any byte being presented is discarded.

Verification
REQ-028 SHALL cover the single transfer: write 8'hA5 at edge 0, with ack driven high one cycle after hs rises and low one cycle after hs falls.
- in_dev_hs=1 after edge 1, with input_bus=A5.
- Pop and tx_cnt=1 after the ack edge.
- hs=0 in WAIT_REL; IDLE is reached after ack falls; empty=1.
REQ-029 SHALL cover fill and overflow: with ack held at 0, write 11,22,33,44,55 on consecutive cycles.
- The fifth write is dropped; full=1, count=4, ovf=1.
- Draining presents 11,22,33,44 in that order, and tx_cnt=4.
REQ-030 SHALL cover the simultaneous case: with the FIFO full and the FSM in PRESENT, assert ld_en=1 with 66 in the same cycle that ack is sampled high.
- The write is accepted, count stays 4 and ovf stays 0.
- 66 is presented fourth after the current byte.
REQ-031 SHALL cover the stale acknowledge: with ack held at 1 while in IDLE and 2 bytes queued, the FSM stays in IDLE and hs=0; after ack drops, hs rises one cycle later.
REQ-032 SHALL cover reset mid-operation: with the FSM in PRESENT holding 3 bytes, pulse g_clr=1 for one cycle.
- Next edge: hs=0, input_bus=00, count=0, tx_cnt=0, tx_state=0.
- A later ack pulse causes no pop.
REQ-033 SHALL cover wrap-around: run 256 transfers followed by one more.
- tx_cnt reads 0 after the 256th transfer and 1 after the 257th.
- Pointer wrap preserves byte order across at least 3 FIFO laps.
